// File: rtl/fw_axil_master.sv
// Single-outstanding AXI-Lite master: turns a simple command/response port into
// AW+W/B or AR/R transactions, presenting each channel's valid without waiting for ready.
module fw_axil_master #(
    parameter int G_ADDR_W = 5,
    parameter int G_DATA_W = 32
) (
    input  logic                  i_clk,
    input  logic                  aresetn,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_we,
    input  logic [G_ADDR_W-1:0]   i_cmd_addr,
    input  logic [G_DATA_W-1:0]   i_cmd_wdata,
    input  logic [G_DATA_W/8-1:0] i_cmd_wstrb,
    output logic                  o_rsp_valid,
    output logic [G_DATA_W-1:0]   o_rsp_data,
    output logic [1:0]            o_rsp_resp,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [G_ADDR_W-1:0]   m_axil_awaddr,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    output logic [G_DATA_W-1:0]   m_axil_wdata,
    output logic [G_DATA_W/8-1:0] m_axil_wstrb,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    input  logic [1:0]            m_axil_bresp,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    output logic [G_ADDR_W-1:0]   m_axil_araddr,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready,
    input  logic [G_DATA_W-1:0]   m_axil_rdata,
    input  logic [1:0]            m_axil_rresp
);

    typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA} state_t;

    state_t                  state;
    logic [G_ADDR_W-1:0]     addr_q;
    logic [G_DATA_W-1:0]     wdata_q;
    logic [G_DATA_W/8-1:0]   wstrb_q;
    logic                    aw_done;
    logic                    w_done;

    assign o_cmd_ready   = (state == IDLE) && aresetn;
    assign m_axil_awaddr = addr_q;
    assign m_axil_araddr = addr_q;
    assign m_axil_wdata  = wdata_q;
    assign m_axil_wstrb  = wstrb_q;

    // A channel counts as done once its valid has dropped or handshakes this edge.
    assign aw_done = !m_axil_awvalid || m_axil_awready;
    assign w_done  = !m_axil_wvalid  || m_axil_wready;

    always_ff @(posedge i_clk) begin
        if (!aresetn) begin
            state          <= IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            m_axil_awvalid <= 1'b0;
            m_axil_wvalid  <= 1'b0;
            m_axil_bready  <= 1'b0;
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b0;
            o_rsp_valid    <= 1'b0;
            o_rsp_data     <= '0;
            o_rsp_resp     <= '0;
        end else begin
            o_rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        addr_q  <= i_cmd_addr;
                        wdata_q <= i_cmd_wdata;
                        wstrb_q <= i_cmd_wstrb;
                        if (i_cmd_we) begin
                            m_axil_awvalid <= 1'b1;
                            m_axil_wvalid  <= 1'b1;
                            state          <= WRITE;
                        end else begin
                            m_axil_arvalid <= 1'b1;
                            state          <= RADDR;
                        end
                    end
                end
                WRITE: begin
                    if (m_axil_awvalid && m_axil_awready) m_axil_awvalid <= 1'b0;
                    if (m_axil_wvalid && m_axil_wready)   m_axil_wvalid  <= 1'b0;
                    if (aw_done && w_done) begin
                        m_axil_bready <= 1'b1;
                        state         <= WRESP;
                    end
                end
                WRESP: begin
                    if (m_axil_bvalid) begin
                        o_rsp_valid   <= 1'b1;
                        o_rsp_data    <= '0;
                        o_rsp_resp    <= m_axil_bresp;
                        m_axil_bready <= 1'b0;
                        state         <= IDLE;
                    end
                end
                RADDR: begin
                    if (m_axil_arready) begin
                        m_axil_arvalid <= 1'b0;
                        m_axil_rready  <= 1'b1;
                        state          <= RDATA;
                    end
                end
                RDATA: begin
                    if (m_axil_rvalid) begin
                        o_rsp_valid   <= 1'b1;
                        o_rsp_data    <= m_axil_rdata;
                        o_rsp_resp    <= m_axil_rresp;
                        m_axil_rready <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fw_axil_master.sv
// Bench for fw_axil_master: delay-configurable AXI-Lite slave with 4 registers,
// response scoreboard, and per-scenario checks on channel timing.
module tb_fw_axil_master;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          i_clk = 1'b0;
    logic          aresetn = 1'b0;
    logic          i_cmd_valid = 1'b0;
    logic          o_cmd_ready;
    logic          i_cmd_we = 1'b0;
    logic [AW-1:0] i_cmd_addr = '0;
    logic [DW-1:0] i_cmd_wdata = '0;
    logic [SW-1:0] i_cmd_wstrb = '0;
    logic          o_rsp_valid;
    logic [DW-1:0] o_rsp_data;
    logic [1:0]    o_rsp_resp;
    logic          m_axil_awvalid, m_axil_awready = 1'b0;
    logic [AW-1:0] m_axil_awaddr;
    logic          m_axil_wvalid, m_axil_wready = 1'b0;
    logic [DW-1:0] m_axil_wdata;
    logic [SW-1:0] m_axil_wstrb;
    logic          m_axil_bvalid = 1'b0, m_axil_bready;
    logic [1:0]    m_axil_bresp = 2'b00;
    logic          m_axil_arvalid, m_axil_arready = 1'b0;
    logic [AW-1:0] m_axil_araddr;
    logic          m_axil_rvalid = 1'b0, m_axil_rready;
    logic [DW-1:0] m_axil_rdata = '0;
    logic [1:0]    m_axil_rresp = 2'b00;

    always #5 i_clk = ~i_clk;

    fw_axil_master #(.G_ADDR_W(AW), .G_DATA_W(DW)) dut (
        .i_clk(i_clk), .aresetn(aresetn),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_we(i_cmd_we),
        .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_wstrb(i_cmd_wstrb),
        .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_resp(o_rsp_resp),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready), .m_axil_awaddr(m_axil_awaddr),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready), .m_axil_bresp(m_axil_bresp),
        .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready), .m_axil_araddr(m_axil_araddr),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } rsp_t;

    rsp_t          sb[$];
    int            n_checks = 0;
    int            n_pass = 0;
    logic [DW-1:0] mregs[4];

    // Slave: each ready rises after its valid has been seen for *_dly cycles.
    int            aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    int            aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic          aw_got, w_got, ar_got, b_fire, r_fire;
    logic [AW-1:0] s_awaddr, s_araddr;
    logic [DW-1:0] s_wdata;
    logic [SW-1:0] s_wstrb;
    logic [DW-1:0] sregs[4];

    always @(negedge i_clk) begin
        if (!aresetn) begin
            m_axil_awready = 0; m_axil_wready = 0; m_axil_bvalid = 0;
            m_axil_arready = 0; m_axil_rvalid = 0;
            aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        end else begin
            if (b_fire) begin
                m_axil_bvalid = 0; b_fire = 0; aw_got = 0; w_got = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            end else if (aw_got && w_got && !m_axil_bvalid) begin
                if (b_cnt >= b_dly) begin
                    m_axil_bvalid = 1;
                    m_axil_bresp  = (s_awaddr < 5'h10) ? 2'b00 : 2'b11;
                    if (s_awaddr < 5'h10)
                        for (int b = 0; b < SW; b++)
                            if (s_wstrb[b]) sregs[s_awaddr[3:2]][8*b +: 8] = s_wdata[8*b +: 8];
                end else b_cnt++;
            end
            if (m_axil_awvalid && !aw_got) begin
                m_axil_awready = (aw_cnt >= aw_dly);
                if (!m_axil_awready) aw_cnt++;
            end else m_axil_awready = 0;
            if (m_axil_awvalid && m_axil_awready) begin aw_got = 1; s_awaddr = m_axil_awaddr; end
            if (m_axil_wvalid && !w_got) begin
                m_axil_wready = (w_cnt >= w_dly);
                if (!m_axil_wready) w_cnt++;
            end else m_axil_wready = 0;
            if (m_axil_wvalid && m_axil_wready) begin
                w_got = 1; s_wdata = m_axil_wdata; s_wstrb = m_axil_wstrb;
            end
            if (m_axil_bvalid && m_axil_bready) b_fire = 1;

            if (r_fire) begin
                m_axil_rvalid = 0; r_fire = 0; ar_got = 0; ar_cnt = 0; r_cnt = 0;
            end else if (ar_got && !m_axil_rvalid) begin
                if (r_cnt >= r_dly) begin
                    m_axil_rvalid = 1;
                    m_axil_rresp  = (s_araddr < 5'h10) ? 2'b00 : 2'b11;
                    m_axil_rdata  = (s_araddr < 5'h10) ? sregs[s_araddr[3:2]]
                                                       : (32'hBAD0_0000 | 32'(s_araddr));
                end else r_cnt++;
            end
            if (m_axil_arvalid && !ar_got) begin
                m_axil_arready = (ar_cnt >= ar_dly);
                if (!m_axil_arready) ar_cnt++;
            end else m_axil_arready = 0;
            if (m_axil_arvalid && m_axil_arready) begin ar_got = 1; s_araddr = m_axil_araddr; end
            if (m_axil_rvalid && m_axil_rready) r_fire = 1;
        end
    end

    // Monitor: scoreboard pops, response timing, per-channel activity counters.
    int            aw_hi, w_hi, ar_hi, bready_hi, rsp_cnt, awaddr_chg, araddr_chg, overlap;
    logic          prev_awv = 0, prev_arv = 0, prev_hs = 0;
    logic [AW-1:0] last_awaddr, last_araddr;
    rsp_t          exp_r;

    always @(negedge i_clk) begin
        #1;
        if (o_rsp_valid || prev_hs) begin
            n_checks++;
            if (o_rsp_valid !== prev_hs)
                $display("FAIL rsp_timing: rsp_valid=%0b required=%0b at %0t", o_rsp_valid, prev_hs, $time);
            else n_pass++;
        end
        if (o_rsp_valid) begin
            rsp_cnt++;
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL rsp_unexpected: got data=%h resp=%b, required no response", o_rsp_data, o_rsp_resp);
            end else begin
                exp_r = sb.pop_front();
                if (o_rsp_data !== exp_r.data || o_rsp_resp !== exp_r.resp)
                    $display("FAIL rsp_payload: got data=%h resp=%b, required data=%h resp=%b",
                             o_rsp_data, o_rsp_resp, exp_r.data, exp_r.resp);
                else n_pass++;
            end
        end
        if (m_axil_awvalid) begin
            if (prev_awv && m_axil_awaddr !== last_awaddr) awaddr_chg++;
            last_awaddr = m_axil_awaddr; aw_hi++;
        end
        if (m_axil_arvalid) begin
            if (prev_arv && m_axil_araddr !== last_araddr) araddr_chg++;
            last_araddr = m_axil_araddr; ar_hi++;
        end
        if (m_axil_wvalid) w_hi++;
        if (m_axil_bready) bready_hi++;
        if ((m_axil_awvalid || m_axil_wvalid || m_axil_bready) && (m_axil_arvalid || m_axil_rready)) overlap++;
        prev_awv = m_axil_awvalid;
        prev_arv = m_axil_arvalid;
        prev_hs  = aresetn && ((m_axil_bvalid && m_axil_bready) || (m_axil_rvalid && m_axil_rready));
    end

    task automatic clr_mon();
        aw_hi = 0; w_hi = 0; ar_hi = 0; bready_hi = 0; rsp_cnt = 0;
        awaddr_chg = 0; araddr_chg = 0; overlap = 0;
    endtask

    task automatic push_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        rsp_t r;
        r.data = '0;
        r.resp = (a < 5'h10) ? 2'b00 : 2'b11;
        if (a < 5'h10)
            for (int b = 0; b < SW; b++) if (s[b]) mregs[a[3:2]][8*b +: 8] = d[8*b +: 8];
        sb.push_back(r);
    endtask

    task automatic push_read(input logic [AW-1:0] a);
        rsp_t r;
        r.resp = (a < 5'h10) ? 2'b00 : 2'b11;
        r.data = (a < 5'h10) ? mregs[a[3:2]] : (32'hBAD0_0000 | 32'(a));
        sb.push_back(r);
    endtask

    task automatic send_cmd(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        bit ok = 0;
        @(posedge i_clk); #1;
        i_cmd_valid = 1; i_cmd_we = we; i_cmd_addr = a; i_cmd_wdata = d; i_cmd_wstrb = s;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge i_clk);
            if (o_cmd_ready) ok = 1;
        end
        @(posedge i_clk); #1;
        i_cmd_valid = 0;
        if (!ok) begin
            n_checks++;
            $display("FAIL cmd_accept: cmd_ready=0 after 200 cycles, required 1");
        end
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge i_clk);
            if (sb.size() == 0) ok = 1;
        end
        repeat (2) @(negedge i_clk);
        n_checks++;
        if (!ok) $display("FAIL rsp_timeout: %0d responses outstanding, required 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        aresetn = 0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk); #2;
        n_checks++;
        if ({m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready, o_cmd_ready, o_rsp_valid} !== 7'b0)
            $display("FAIL reset_ctrl: got %b required 0000000",
                     {m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready, o_cmd_ready, o_rsp_valid});
        else n_pass++;
        n_checks++;
        if (o_rsp_data !== '0 || o_rsp_resp !== 2'b00)
            $display("FAIL reset_rsp: got data=%h resp=%b required 0/00", o_rsp_data, o_rsp_resp);
        else n_pass++;
        @(posedge i_clk); #1;
        aresetn = 1;
        @(negedge i_clk); #2;
        n_checks++;
        if (o_cmd_ready !== 1'b1) $display("FAIL reset_release_ready: got %b required 1", o_cmd_ready);
        else n_pass++;
    endtask

    task automatic test_write_read();
        clr_mon();
        push_write(5'h04, 32'hDEADBEEF, 4'hF); send_cmd(1, 5'h04, 32'hDEADBEEF, 4'hF); wait_done();
        push_read(5'h04); send_cmd(0, 5'h04, 32'h0, 4'h0); wait_done();
        n_checks++;
        if (rsp_cnt !== 2) $display("FAIL wr_rd_count: got %0d required 2", rsp_cnt);
        else n_pass++;
    endtask

    task automatic test_strobe();
        push_write(5'h08, 32'h11223344, 4'hF); send_cmd(1, 5'h08, 32'h11223344, 4'hF); wait_done();
        push_write(5'h08, 32'hAABBCCDD, 4'b0101); send_cmd(1, 5'h08, 32'hAABBCCDD, 4'b0101); wait_done();
        push_read(5'h08); send_cmd(0, 5'h08, 32'h0, 4'h0); wait_done();
        push_read(5'h0C); send_cmd(0, 5'h0C, 32'hFFFFFFFF, 4'hF); wait_done();
    endtask

    task automatic test_bad_addr();
        clr_mon();
        ar_dly = 2;
        push_read(5'h10); send_cmd(0, 5'h10, 32'h0, 4'h0); wait_done();
        n_checks++;
        if (ar_hi !== 3 || araddr_chg !== 0)
            $display("FAIL arvalid_hold: got cycles=%0d changes=%0d required 3/0", ar_hi, araddr_chg);
        else n_pass++;
        ar_dly = 0;
        push_write(5'h14, 32'h12345678, 4'hF); send_cmd(1, 5'h14, 32'h12345678, 4'hF); wait_done();
    endtask

    task automatic test_aw_delay();
        clr_mon();
        aw_dly = 3;
        push_write(5'h0C, 32'hCAFEF00D, 4'hF); send_cmd(1, 5'h0C, 32'hCAFEF00D, 4'hF); wait_done();
        aw_dly = 0;
        n_checks++;
        if (aw_hi !== 4 || w_hi !== 1 || awaddr_chg !== 0 || rsp_cnt !== 1)
            $display("FAIL aw_delay: got aw=%0d w=%0d chg=%0d rsp=%0d required 4/1/0/1", aw_hi, w_hi, awaddr_chg, rsp_cnt);
        else n_pass++;
        clr_mon();
        w_dly = 2;
        push_write(5'h00, 32'h0BADF00D, 4'b1100); send_cmd(1, 5'h00, 32'h0BADF00D, 4'b1100); wait_done();
        w_dly = 0;
        n_checks++;
        if (aw_hi !== 1 || w_hi !== 3 || rsp_cnt !== 1)
            $display("FAIL w_delay: got aw=%0d w=%0d rsp=%0d required 1/3/1", aw_hi, w_hi, rsp_cnt);
        else n_pass++;
    endtask

    task automatic test_b_delay();
        clr_mon();
        b_dly = 5;
        push_write(5'h04, 32'h5555AAAA, 4'hF); send_cmd(1, 5'h04, 32'h5555AAAA, 4'hF); wait_done();
        b_dly = 0;
        n_checks++;
        if (bready_hi !== 6 || rsp_cnt !== 1)
            $display("FAIL b_delay: got bready_cycles=%0d rsp=%0d required 6/1", bready_hi, rsp_cnt);
        else n_pass++;
        push_read(5'h04); send_cmd(0, 5'h04, 32'h0, 4'h0); wait_done();
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        clr_mon();
        r_dly = 20;
        send_cmd(0, 5'h04, 32'h0, 4'h0);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge i_clk);
            if (m_axil_rready) seen = 1;
        end
        n_checks++;
        if (!seen) $display("FAIL rdata_entry: rready=0, required 1");
        else n_pass++;
        @(posedge i_clk); #1; aresetn = 0;
        @(posedge i_clk); #1; aresetn = 1;
        @(negedge i_clk); #2;
        n_checks++;
        if ({m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready, o_rsp_valid} !== 6'b0 || o_cmd_ready !== 1'b1)
            $display("FAIL mid_reset: got ctrl=%b cmd_ready=%b required 000000/1",
                     {m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready, o_rsp_valid}, o_cmd_ready);
        else n_pass++;
        r_dly = 0;
        repeat (5) @(negedge i_clk);
        n_checks++;
        if (rsp_cnt !== 0) $display("FAIL mid_reset_rsp: got %0d pulses required 0", rsp_cnt);
        else n_pass++;
        mregs[1] = 32'h0;
        push_write(5'h04, 32'h0, 4'hF); send_cmd(1, 5'h04, 32'h0, 4'hF); wait_done();
    endtask

    task automatic test_back_to_back();
        bit ok = 0;
        bit ok2 = 0;
        logic rv_at_accept = 0;
        clr_mon();
        push_write(5'h00, 32'h00005A5A, 4'hF);
        push_read(5'h00);
        @(posedge i_clk); #1;
        i_cmd_valid = 1; i_cmd_we = 1; i_cmd_addr = 5'h00; i_cmd_wdata = 32'h00005A5A; i_cmd_wstrb = 4'hF;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge i_clk);
            if (o_cmd_ready) ok = 1;
        end
        @(posedge i_clk); #1;
        i_cmd_we = 0; i_cmd_addr = 5'h00;
        for (int i = 0; i < 50 && !ok2; i++) begin
            @(negedge i_clk); #2;
            if (o_cmd_ready) begin ok2 = 1; rv_at_accept = o_rsp_valid; end
        end
        @(posedge i_clk); #1;
        i_cmd_valid = 0;
        n_checks++;
        if (!ok || !ok2 || rv_at_accept !== 1'b1)
            $display("FAIL b2b_accept: got accepted=%b%b rsp_valid_at_accept=%b required 11/1", ok, ok2, rv_at_accept);
        else n_pass++;
        wait_done();
        n_checks++;
        if (overlap !== 0 || rsp_cnt !== 2)
            $display("FAIL b2b_overlap: got overlap=%0d rsp=%0d required 0/2", overlap, rsp_cnt);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin mregs[i] = '0; sregs[i] = '0; end
        clr_mon();
        test_reset();
        test_write_read();
        test_strobe();
        test_bad_addr();
        test_aw_delay();
        test_b_delay();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fw_axil_master.md
FW_AXIL_MASTER -- requirements
Module: fw_axil_master

Interface
REQ-001 Parameter G_ADDR_W, default 5, SHALL set the AXI-Lite address width and the command address width.
REQ-002 Parameter G_DATA_W, default 32, SHALL set the data width in bits; strobe width is G_DATA_W/8.
REQ-003 i_clk  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-004 aresetn  in  1  reset, synchronous, active-low.
REQ-005 i_cmd_valid  in  1  command present.
REQ-006 o_cmd_ready  out  1  block can accept a command.
REQ-007 i_cmd_we  in  1  1 = write, 0 = read.
REQ-008 i_cmd_addr  in  G_ADDR_W  target address, forwarded unmodified.
REQ-009 i_cmd_wdata  in  G_DATA_W  write data (ignored on read).
REQ-010 i_cmd_wstrb  in  G_DATA_W/8  write strobes (ignored on read).
REQ-011 o_rsp_valid  out  1  one-cycle completion pulse, no backpressure.
REQ-012 o_rsp_data  out  G_DATA_W  read data; 0 for writes.
REQ-013 o_rsp_resp  out  2  BRESP/RRESP of the completed transaction.
REQ-014 m_axil_awvalid  out  1 / m_axil_awready  in  1 / m_axil_awaddr  out  G_ADDR_W: write address channel.
REQ-015 m_axil_wvalid  out  1 / m_axil_wready  in  1 / m_axil_wdata  out  G_DATA_W / m_axil_wstrb  out  G_DATA_W/8: write data channel.
REQ-016 m_axil_bvalid  in  1 / m_axil_bready  out  1 / m_axil_bresp  in  2: write response channel.
REQ-017 m_axil_arvalid  out  1 / m_axil_arready  in  1 / m_axil_araddr  out  G_ADDR_W: read address channel.
REQ-018 m_axil_rvalid  in  1 / m_axil_rready  out  1 / m_axil_rdata  in  G_DATA_W / m_axil_rresp  in  2: read data channel.

Function
REQ-019 FSM states SHALL be IDLE, WRITE, WRESP, RADDR and RDATA; one transaction outstanding at a time.
REQ-020 o_cmd_ready SHALL be 1 only in IDLE with aresetn high; a command is accepted on i_cmd_valid & o_cmd_ready, and addr/wdata/wstrb/we are registered.
REQ-021 Accepted write: next cycle state WRITE, with awvalid and wvalid both 1 and the registered addr/data/strb driven.
REQ-022 In WRITE, awvalid and wvalid SHALL each drop the cycle after its own handshake; when both have handshaken (same or different cycles), state WRESP, bready = 1.
REQ-023 In WRESP, on bvalid & bready: o_rsp_valid = 1 for one cycle, o_rsp_resp = bresp, o_rsp_data = 0, bready = 0, state IDLE.
REQ-024 Accepted read: next cycle state RADDR, arvalid = 1 with the registered address; on arvalid & arready, arvalid = 0, rready = 1, state RDATA.
REQ-025 In RDATA, on rvalid & rready: o_rsp_valid pulse, o_rsp_data = rdata, o_rsp_resp = rresp, rready = 0, state IDLE.
REQ-026 A valid output SHALL never deassert, and its payload SHALL never change, before its handshake; it SHALL NOT wait for the slave ready.
REQ-027 bready SHALL be 1 only in WRESP; rready SHALL be 1 only in RDATA; an early awready/wready/arready (before valid) SHALL be legal.
REQ-028 o_rsp_valid and o_cmd_ready SHALL be high in the same cycle, so a held command is accepted in that cycle.
REQ-029 o_rsp_data/o_rsp_resp SHALL hold their last values between pulses.
REQ-030 Response codes SHALL be passed through unaltered; no timeout and no retry.

Reset
REQ-031 While aresetn = 0 at an edge: state IDLE; all m_axil valid/ready outputs 0; o_cmd_ready 0; o_rsp_valid 0; o_rsp_data 0; o_rsp_resp 0.
REQ-032 Reset mid-transaction SHALL abandon it with no o_rsp_valid pulse; o_cmd_ready = 1 the first cycle after release.

Verification
REQ-033 Slave with 4 registers at 0x00..0x0C: write 0xDEADBEEF to 0x04, then read 0x04 -> write rsp resp 00; read rsp data 0xDEADBEEF, resp 00.
REQ-034 Read 0x10 on the same slave -> arvalid held until arready; rsp resp 11, data equals slave rdata.
REQ-035 wready immediate, awready delayed 3 cycles -> wvalid drops after 1 cycle; awvalid and awaddr stable 4 cycles; exactly one rsp pulse after bvalid.
REQ-036 bvalid delayed 5 cycles after the W handshake -> bready held high throughout; rsp pulse the cycle after the B handshake, never earlier.
REQ-037 aresetn low for 1 cycle while in RDATA -> next cycle all valids/readies 0, no rsp pulse; o_cmd_ready 1 after release.
REQ-038 i_cmd_valid held with two queued commands -> second accepted in the same cycle as the first rsp pulse; no AXI valid overlap.
